// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the sequential ALU.
//   Op codes (OP_NOTA..OP_MUL), FSM state type, flag bit positions.
//   Codes 0..7 keep the legacy 3-bit encodings under op[3]=0.
//   13..15 are reserved.
package alu_pkg;

  localparam logic [3:0] OP_NOTA = 4'd0;
  localparam logic [3:0] OP_NOTB = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int FLG_C = 0;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 3;
  localparam int FLG_W = 4;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the register file side and the ALU.
//   master (requester): drives in_valid, a, b, op; observes in_ready and all results.
//   slave  (ALU)      : drives in_ready, out_valid, result, result_hi, c, n, z, v, op_err.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             c;
  logic             n;
  logic             z;
  logic             v;
  logic             op_err;

  modport master (
    output in_valid, a, b, op,
    input  in_ready, out_valid, result, result_hi, c, n, z, v, op_err
  );

  modport slave (
    input  in_valid, a, b, op,
    output in_ready, out_valid, result, result_hi, c, n, z, v, op_err
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle.
//   clk, reset  : clock, synchronous active-high reset (aborts a running multiply)
//   i_start     : load operands and begin (ignored while busy by the caller)
//   i_a, i_b    : multiplicand, multiplier
//   o_busy      : a multiply is in progress
//   o_done      : final step happens at the coming edge
//   o_prod      : product after the current step; the full product when o_done=1
module alu_mul_seq #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  // upper half accumulates, lower half holds the not-yet-consumed multiplier bits
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_step;

  assign w_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_step = {w_sum, r_prod[WIDTH-1:1]};

  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == CW'(1));
  // exposing the step result lets the caller register the product on the last edge
  assign o_prod = w_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
    end else if (i_start) begin
      r_cnt   <= CW'(WIDTH);
      r_mcand <= i_a;
      r_prod  <= {{WIDTH{1'b0}}, i_b};
    end else if (o_busy) begin
      r_cnt   <= r_cnt - CW'(1);
      r_prod  <= w_step;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready input and a one-cycle out_valid pulse.
//   clk, reset : clock, synchronous active-high reset
//   bus        : alu_seq_if.slave (in_valid/in_ready/a/b/op in; out_valid/result/
//                result_hi/c/n/z/v/op_err out)
//   Optional feature macro ALU_MUL_EN: when defined, op 12 is a WIDTH-cycle
//   unsigned multiply; when undefined, op 12 is reserved and in_ready stays 1.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam int M = WIDTH - 1;

  state_t             r_state, w_state_nxt;
  logic               w_accept, w_is_mul, w_mul_busy, w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH:0]     w_sum;
  logic [FLG_W-1:0]   w_flg;
  logic               w_err;
  logic [SHW-1:0]     w_sh;

  logic               r_out_valid, r_c, r_n, r_z, r_v, r_err;
  logic [WIDTH-1:0]   r_result, r_result_hi;

  assign bus.in_ready = (r_state == ST_IDLE);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_sh         = bus.b[SHW-1:0];

`ifdef ALU_MUL_EN
  assign w_is_mul = (bus.op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept & w_is_mul),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_busy = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_prod     = '0;
`endif

  // ---------------- state machine ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_mul) w_state_nxt = ST_MUL;
      // !busy only guards against a stuck MUL state; done is the normal exit
      ST_MUL:  if (w_mul_done || !w_mul_busy) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- single-cycle op mux + flags ----------------
  always_comb begin
    w_res = '0;
    w_sum = '0;
    w_flg = '0;
    w_err = 1'b0;
    case (bus.op)
      OP_NOTA: w_res = ~bus.a;
      OP_NOTB: w_res = ~bus.b;
      OP_AND:  w_res = bus.a & bus.b;
      OP_OR:   w_res = bus.a | bus.b;
      OP_XOR:  w_res = bus.a ^ bus.b;
      OP_XNOR: w_res = ~(bus.a ^ bus.b);
      OP_ADD: begin
        w_sum        = {1'b0, bus.a} + {1'b0, bus.b};
        w_res        = w_sum[M:0];
        w_flg[FLG_C] = w_sum[WIDTH];
        w_flg[FLG_V] = (bus.a[M] == bus.b[M]) & (w_res[M] != bus.a[M]);
      end
      OP_SUB: begin
        // carry out of a + ~b + 1: 1 means no borrow
        w_sum        = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        w_res        = w_sum[M:0];
        w_flg[FLG_C] = w_sum[WIDTH];
        w_flg[FLG_V] = (bus.a[M] != bus.b[M]) & (w_res[M] != bus.a[M]);
      end
      OP_SLL:  w_res = bus.a << w_sh;
      OP_SRL:  w_res = bus.a >> w_sh;
      OP_SRA:  w_res = WIDTH'($signed(bus.a) >>> w_sh);
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      // reserved codes, and op 12 when the multiplier is not built
      default: w_err = 1'b1;
    endcase
    w_flg[FLG_N] = w_res[M];
    w_flg[FLG_Z] = (w_res == '0);
  end

  // ---------------- output registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_c         <= 1'b0;
      r_n         <= 1'b0;
      r_z         <= 1'b1;
      r_v         <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      // done only fires in ST_MUL, where in_ready=0, so the two branches never collide
      if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_result    <= w_prod[M:0];
        r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_c         <= (w_prod[2*WIDTH-1:WIDTH] != '0);
        r_n         <= w_prod[M];
        r_z         <= (w_prod[M:0] == '0);
        r_v         <= 1'b0;
        r_err       <= 1'b0;
      end else if (w_accept && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_result_hi <= '0;
        r_c         <= w_flg[FLG_C];
        r_n         <= w_flg[FLG_N];
        r_z         <= w_flg[FLG_Z];
        r_v         <= w_flg[FLG_V];
        r_err       <= w_err;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.c         = r_c;
  assign bus.n         = r_n;
  assign bus.z         = r_z;
  assign bus.v         = r_v;
  assign bus.op_err    = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed stimulus for alu_seq with a transaction-level reference
// model and a per-cycle output compare; follows ALU_MUL_EN like the RTL does.
module tb_alu_seq;
  localparam int W = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic c, n, z, v, err;
    int   due;
  } exp_t;

  exp_t q[$];
  exp_t last, m_e;
  int   cyc = 0;
  int   ready_from = 0;
  bit   armed = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic exp_valid, exp_ready;

  // reference: what the result of one operation must be, from plain arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, ss;
    logic [63:0] ua, ub, p;
    e.res = '0; e.hi = '0; e.c = 0; e.v = 0; e.err = 0; e.due = 0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a}; ub = {32'b0, b};
    case (op)
      4'd0: e.res = ~a;
      4'd1: e.res = ~b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ~(a ^ b);
      4'd6: begin
        e.res = a + b;
        p = ua + ub; e.c = (p > 64'hFFFF_FFFF);
        ss = sa + sb; e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd7: begin
        e.res = a - b;
        e.c = (a >= b);
        ss = sa - sb; e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd8:  e.res = a << b[4:0];
      4'd9:  e.res = a >> b[4:0];
      4'd10: e.res = $signed(a) >>> b[4:0];
      4'd11: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: begin
        if (MUL_EN) begin
          p = ua * ub; e.res = p[31:0]; e.hi = p[63:32]; e.c = (e.hi != 0);
        end else e.err = 1'b1;
      end
      default: e.err = 1'b1;
    endcase
    e.n = e.res[W-1];
    e.z = (e.res == '0);
    return e;
  endfunction

  // model side: track accepts and when their results are due
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      last.res = '0; last.hi = '0; last.c = 0; last.n = 0; last.z = 1; last.v = 0; last.err = 0; last.due = 0;
      ready_from = cyc + 1;
      armed = 1'b1;
    end else if (bus.in_valid && cyc >= ready_from) begin
      m_e = model(bus.op, bus.a, bus.b);
      if (MUL_EN && bus.op == 4'd12) begin
        m_e.due = cyc + W + 1;
        ready_from = cyc + W + 1;
      end else begin
        m_e.due = cyc + 1;
      end
      q.push_back(m_e);
    end
    cyc++;
  end

  // every-cycle compare of handshake and held outputs
  always @(negedge clk) begin
    if (armed) begin
      exp_valid = (q.size() > 0) && (q[0].due == cyc);
      if (exp_valid) last = q.pop_front();
      exp_ready = (cyc >= ready_from);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.result_hi, bus.c, bus.n, bus.z, bus.v, bus.op_err} !==
          {exp_valid, exp_ready, last.res, last.hi, last.c, last.n, last.z, last.v, last.err}) begin
        errors++;
        $display("FAIL cycle%0d: got vld=%b rdy=%b res=%h hi=%h cnzv=%b%b%b%b err=%b; want vld=%b rdy=%b res=%h hi=%h cnzv=%b%b%b%b err=%b",
                 cyc, bus.out_valid, bus.in_ready, bus.result, bus.result_hi, bus.c, bus.n, bus.z, bus.v, bus.op_err,
                 exp_valid, exp_ready, last.res, last.hi, last.c, last.n, last.z, last.v, last.err);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, g);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // hand-computed expectation; flags given as {c,n,z,v,err}
  task automatic lit(input string nm, input logic [W-1:0] res, input logic [W-1:0] hi, input logic [4:0] f);
    checks++;
    if ({bus.out_valid, bus.result, bus.result_hi, bus.c, bus.n, bus.z, bus.v, bus.op_err} !== {1'b1, res, hi, f}) begin
      errors++;
      $display("FAIL %s: got vld=%b res=%h hi=%h cnzve=%b%b%b%b%b, want vld=1 res=%h hi=%h cnzve=%b",
               nm, bus.out_valid, bus.result, bus.result_hi, bus.c, bus.n, bus.z, bus.v, bus.op_err, res, hi, f);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  logic [3:0]  t_op[12] = '{4'd0, 4'd1, 4'd5, 4'd8, 4'd8, 4'd9, 4'd10, 4'd11, 4'd11, 4'd6, 4'd7, 4'd11};
  logic [31:0] t_a [12] = '{32'h0F0F_0000, 32'h1, 32'hAAAA_5555, 32'h1234_5678, 32'h1, 32'h8000_0000,
                            32'h7000_0000, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h5};
  logic [31:0] t_b [12] = '{32'h0, 32'h0000_00FF, 32'hAAAA_AAAA, 32'h20, 32'h1F, 32'h3F,
                            32'h8, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h5};

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    lit_reset: begin
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_z", int'(bus.z), 1);
    end
    reset = 1'b0;

    // overflowing add
    send(4'd6, 32'h7FFF_FFFF, 32'h1); idle();
    lit("add_ovf", 32'h8000_0000, 32'h0, 5'b01010);
    // subtract to zero, then borrow
    send(4'd7, 32'h5, 32'h5); idle();
    lit("sub_zero", 32'h0, 32'h0, 5'b10100);
    send(4'd7, 32'h0, 32'h1); idle();
    lit("sub_borrow", 32'hFFFF_FFFF, 32'h0, 5'b01000);
    // back-to-back single-cycle ops
    send(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    send(4'd3, 32'hF0F0_F0F0, 32'h0F00_000F);
    send(4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F);
    send(4'd10, 32'h8000_0000, 32'h4); idle();
    lit("sra_fill", 32'hF800_0000, 32'h0, 5'b01000);
    // assorted ops incl. shift-by-0 and shift amount taken from low bits only
    for (int i = 0; i < 12; i++) send(t_op[i], t_a[i], t_b[i]);
    idle();
    repeat (2) @(negedge clk);

    if (MUL_EN) begin
      send(4'd12, 32'hFFFF_FFFF, 32'h2);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.op = 4'd6; bus.a = 32'h3; bus.b = 32'h4;
      n = 1;
      chk("mul_busy_ready", int'(bus.in_ready), 0);
      while (!bus.out_valid && n < 60) begin @(negedge clk); n++; end
      chk("mul_latency", n, W + 1);
      lit("mul_result", 32'hFFFF_FFFE, 32'h1, 5'b11000);
      chk("mul_done_ready", int'(bus.in_ready), 1);
      @(posedge clk); idle();
      lit("add_after_mul", 32'h7, 32'h0, 5'b00000);
      send(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      send(4'd12, 32'h0, 32'h1234_5678); idle();
      repeat (2 * W + 6) @(negedge clk);
    end else begin
      send(4'd12, 32'hFFFF_FFFF, 32'h2); idle();
      lit("op12_reserved", 32'h0, 32'h0, 5'b00101);
      chk("op12_ready", int'(bus.in_ready), 1);
    end

    // reset during a multiply
    send(4'd12, 32'h1234, 32'h5678); idle();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_ready", int'(bus.in_ready), 1);
    chk("abort_result", int'(bus.result != 0), 0);
    chk("abort_z", int'(bus.z), 1);
    repeat (W + 4) @(negedge clk);

    // reserved codes
    send(4'd13, 32'hDEAD_BEEF, 32'h1); idle();
    lit("op13_reserved", 32'h0, 32'h0, 5'b00101);
    send(4'd14, 32'h1, 32'h1);
    send(4'd15, 32'h1, 32'h1);
    send(4'd6, 32'hFFFF_FFFF, 32'h1); idle();
    lit("add_carry_after_rsvd", 32'h0, 32'h0, 5'b10100);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
